// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, controller
// state encoding and the datapath mux/ALU select encodings.
package riscv_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] LOAD           = 7'b0000011;
    localparam logic [6:0] STORE          = 7'b0100011;
    localparam logic [6:0] BRANCH         = 7'b1100011;
    localparam logic [6:0] JAL            = 7'b1101111;
    localparam logic [6:0] JALR           = 7'b1100111;
    localparam logic [6:0] ECALL          = 7'b1110011;

    // Controller states
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // PC source select
    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_TARGET = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    // Register write-back source
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    // True for opcodes that continue past decode into EX.
    function automatic logic needs_ex(input logic [6:0] op);
        return (op == ARITHMETIC) || (op == ARITHMETIC_IMM) ||
               (op == LOAD)       || (op == STORE)          ||
               (op == BRANCH)     || (op == JAL)            ||
               (op == JALR);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-output decode for the multi-cycle controller.
// Outputs depend only on the current state, opcode, bcond and mem_ready;
// halt_req tells decode whether an ECALL in ID is the terminating one.
module mc_output_decode
    import riscv_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       is_halted
);

    // Per-state output decode; everything not named for a state stays 0.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PC_SRC_PC4;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_RS2;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = M2R_ALU;
        is_halted  = 1'b0;
        case (state)
            S_IF: begin
                // Instruction fetch: address from PC, capture IR on completion.
                mem_read = 1'b1;
                i_or_d   = 1'b0;
                ir_write = mem_ready;
            end
            S_ID: begin
                // ALU forms PC+4 while the register file is read.
                alu_src_a = 1'b0;
                alu_src_b = ALU_B_FOUR;
                alu_op    = ALU_OP_ADD;
                // ECALL (non-halting) and unknown opcodes retire here as NOPs.
                if (!needs_ex(opcode) && !((opcode == ECALL) && halt_req)) begin
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_PC4;
                end
            end
            S_EX: begin
                case (opcode)
                    ARITHMETIC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = ALU_B_RS2;
                        alu_op    = ALU_OP_FUNCT;
                    end
                    ARITHMETIC_IMM: begin
                        alu_src_a = 1'b1;
                        alu_src_b = ALU_B_IMM;
                        alu_op    = ALU_OP_FUNCT;
                    end
                    LOAD, STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = ALU_B_IMM;
                        alu_op    = ALU_OP_ADD;
                    end
                    BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_src_b = ALU_B_RS2;
                        alu_op    = ALU_OP_BRANCH;
                        pc_write  = 1'b1;
                        pc_source = bcond ? PC_SRC_TARGET : PC_SRC_PC4;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Data access: address from ALU-out, strobe held until ready.
                i_or_d = 1'b1;
                if (opcode == LOAD) begin
                    mem_read = 1'b1;
                end else if (opcode == STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write  = 1'b1;
                        pc_source = PC_SRC_PC4;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (opcode)
                    LOAD: mem_to_reg = M2R_MDR;
                    JAL: begin
                        mem_to_reg = M2R_PC4;
                        pc_source  = PC_SRC_TARGET;
                    end
                    JALR: begin
                        mem_to_reg = M2R_PC4;
                        pc_source  = PC_SRC_JALR;
                    end
                    default: begin
                        mem_to_reg = M2R_ALU;
                        pc_source  = PC_SRC_PC4;
                    end
                endcase
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: holds the state register and
// next-state logic; control outputs come from mc_output_decode and are
// forced to 0 while reset_n is low.
// Build option ECALL_HALT_EN: when defined, ECALL with ecall_halt=1 enters
// the terminal HALT state; otherwise ECALL is a NOP and is_halted is 0.
// Handshake: a memory request (mem_read/mem_write with i_or_d) is held
// stable every cycle until mem_ready is seen high in IF or MEM; mem_ready
// in any other state is ignored.
module multicycle_control_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       mem_ready,
    input  logic       ecall_halt,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       is_halted,
    output logic [2:0] dbg_state
);

    state_t state;
    state_t state_next;
    logic   halt_req;

    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_i_or_d;
    logic       dec_ir_write;
    logic       dec_pc_write;
    logic [1:0] dec_pc_source;
    logic       dec_alu_src_a;
    logic [1:0] dec_alu_src_b;
    logic [1:0] dec_alu_op;
    logic       dec_reg_write;
    logic [1:0] dec_mem_to_reg;
    logic       dec_is_halted;

`ifdef ECALL_HALT_EN
    assign halt_req  = ecall_halt;
    assign is_halted = dec_is_halted & reset_n;
`else
    logic unused_halt;
    assign halt_req    = 1'b0;
    assign is_halted   = 1'b0;
    assign unused_halt = ecall_halt ^ dec_is_halted;
`endif

    // State register; reset returns to IF and drops any pending request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing through IF/ID/EX/MEM/WB.
    always_comb begin
        state_next = state;
        case (state)
            S_IF: begin
                if (mem_ready) state_next = S_ID;
            end
            S_ID: begin
                if ((opcode == ECALL) && halt_req) state_next = S_HALT;
                else if (needs_ex(opcode))         state_next = S_EX;
                else                               state_next = S_IF;
            end
            S_EX: begin
                case (opcode)
                    LOAD, STORE:                       state_next = S_MEM;
                    ARITHMETIC, ARITHMETIC_IMM,
                    JAL, JALR:                         state_next = S_WB;
                    default:                           state_next = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = (opcode == LOAD) ? S_WB : S_IF;
                end
            end
            S_WB:    state_next = S_IF;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    mc_output_decode u_decode (
        .state      (state),
        .opcode     (opcode),
        .bcond      (bcond),
        .mem_ready  (mem_ready),
        .halt_req   (halt_req),
        .mem_read   (dec_mem_read),
        .mem_write  (dec_mem_write),
        .i_or_d     (dec_i_or_d),
        .ir_write   (dec_ir_write),
        .pc_write   (dec_pc_write),
        .pc_source  (dec_pc_source),
        .alu_src_a  (dec_alu_src_a),
        .alu_src_b  (dec_alu_src_b),
        .alu_op     (dec_alu_op),
        .reg_write  (dec_reg_write),
        .mem_to_reg (dec_mem_to_reg),
        .is_halted  (dec_is_halted)
    );

    // Outputs are silenced combinationally while reset is held.
    assign mem_read   = dec_mem_read   & reset_n;
    assign mem_write  = dec_mem_write  & reset_n;
    assign i_or_d     = dec_i_or_d     & reset_n;
    assign ir_write   = dec_ir_write   & reset_n;
    assign pc_write   = dec_pc_write   & reset_n;
    assign pc_source  = dec_pc_source  & {2{reset_n}};
    assign alu_src_a  = dec_alu_src_a  & reset_n;
    assign alu_src_b  = dec_alu_src_b  & {2{reset_n}};
    assign alu_op     = dec_alu_op     & {2{reset_n}};
    assign reg_write  = dec_reg_write  & reset_n;
    assign mem_to_reg = dec_mem_to_reg & {2{reset_n}};
    assign dbg_state  = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed per-cycle vector
// table, hand-written reset/ECALL sequences, and random instruction streams
// checked against a per-instruction trace model.
module tb_multicycle_control_fsm;
    import riscv_pkg::*;

    // Output vector bit masks {mem_read, mem_write, i_or_d, ir_write,
    // pc_write, pc_source[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0],
    // reg_write, mem_to_reg[1:0], is_halted}
    localparam logic [15:0] MR   = 16'h8000;
    localparam logic [15:0] MW   = 16'h4000;
    localparam logic [15:0] IOD  = 16'h2000;
    localparam logic [15:0] IRW  = 16'h1000;
    localparam logic [15:0] PCW  = 16'h0800;
    localparam logic [15:0] PCS1 = 16'h0200;
    localparam logic [15:0] PCS2 = 16'h0400;
    localparam logic [15:0] ASA  = 16'h0100;
    localparam logic [15:0] ASB1 = 16'h0040;
    localparam logic [15:0] ASB2 = 16'h0080;
    localparam logic [15:0] AOP1 = 16'h0010;
    localparam logic [15:0] AOP2 = 16'h0020;
    localparam logic [15:0] RW   = 16'h0008;
    localparam logic [15:0] M2R1 = 16'h0002;
    localparam logic [15:0] M2R2 = 16'h0004;
    localparam logic [15:0] HLT  = 16'h0001;
    localparam logic [15:0] NONE = 16'h0000;
    localparam logic [6:0]  BAD_OP = 7'b1111111;

    typedef struct {
        logic        rn;
        logic [6:0]  op;
        logic        bc;
        logic        rdy;
        logic        eh;
        logic [15:0] exp;
        string       name;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic       bcond;
    logic       mem_ready;
    logic       ecall_halt;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b, alu_op, mem_to_reg;
    logic       alu_src_a, reg_write, is_halted;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t rq[$];

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .bcond      (bcond),
        .mem_ready  (mem_ready),
        .ecall_halt (ecall_halt),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .is_halted  (is_halted),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, is_halted};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (state %0d) at %0t", name, act, exp, dbg_state, $time);
        end
    endtask

    function automatic vec_t mk(input logic rn, input logic [6:0] op, input logic bc,
                                input logic rdy, input logic eh, input logic [15:0] exp,
                                input string name);
        vec_t v;
        v.rn = rn; v.op = op; v.bc = bc; v.rdy = rdy; v.eh = eh; v.exp = exp; v.name = name;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge, check mid-cycle.
    task automatic step(input vec_t v);
        reset_n    = v.rn;
        opcode     = v.op;
        bcond      = v.bc;
        mem_ready  = v.rdy;
        ecall_halt = v.eh;
        @(negedge clk);
        check(v.name, outs(), v.exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference trace for one instruction: the cycle-by-cycle outputs it
    // must produce, written straight from the per-phase control table.
    task automatic gen_instr(input logic [6:0] op, input logic bc, input int if_wait,
                             input int mem_wait, input logic eh);
        for (int w = 0; w < if_wait; w++) rq.push_back(mk(1, op, rb(), 0, eh, MR, "r_if_wait"));
        rq.push_back(mk(1, op, rb(), 1, eh, MR | IRW, "r_if"));
        if (op == ECALL || op == BAD_OP) begin
            rq.push_back(mk(1, op, rb(), rb(), eh, ASB2 | PCW, "r_id_nop"));
            return;
        end
        rq.push_back(mk(1, op, rb(), rb(), eh, ASB2, "r_id"));
        case (op)
            ARITHMETIC: begin
                rq.push_back(mk(1, op, rb(), rb(), eh, ASA | AOP2, "r_ex_r"));
                rq.push_back(mk(1, op, rb(), rb(), eh, RW | PCW, "r_wb_r"));
            end
            ARITHMETIC_IMM: begin
                rq.push_back(mk(1, op, rb(), rb(), eh, ASA | ASB1 | AOP2, "r_ex_i"));
                rq.push_back(mk(1, op, rb(), rb(), eh, RW | PCW, "r_wb_i"));
            end
            LOAD: begin
                rq.push_back(mk(1, op, rb(), rb(), eh, ASA | ASB1, "r_ex_ld"));
                for (int w = 0; w < mem_wait; w++) rq.push_back(mk(1, op, rb(), 0, eh, MR | IOD, "r_mem_ld_wait"));
                rq.push_back(mk(1, op, rb(), 1, eh, MR | IOD, "r_mem_ld"));
                rq.push_back(mk(1, op, rb(), rb(), eh, RW | PCW | M2R1, "r_wb_ld"));
            end
            STORE: begin
                rq.push_back(mk(1, op, rb(), rb(), eh, ASA | ASB1, "r_ex_st"));
                for (int w = 0; w < mem_wait; w++) rq.push_back(mk(1, op, rb(), 0, eh, MW | IOD, "r_mem_st_wait"));
                rq.push_back(mk(1, op, rb(), 1, eh, MW | IOD | PCW, "r_mem_st"));
            end
            BRANCH: begin
                rq.push_back(mk(1, op, bc, rb(), eh, ASA | AOP1 | PCW | (bc ? PCS1 : NONE), "r_ex_br"));
            end
            JAL: begin
                rq.push_back(mk(1, op, rb(), rb(), eh, NONE, "r_ex_jal"));
                rq.push_back(mk(1, op, rb(), rb(), eh, RW | PCW | M2R2 | PCS1, "r_wb_jal"));
            end
            default: begin // JALR
                rq.push_back(mk(1, op, rb(), rb(), eh, NONE, "r_ex_jalr"));
                rq.push_back(mk(1, op, rb(), rb(), eh, RW | PCW | M2R2 | PCS2, "r_wb_jalr"));
            end
        endcase
    endtask

    initial begin
        logic [6:0] ops [9];
        vec_t v;
        ops = '{ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL, BAD_OP};

        reset_n = 1'b0; opcode = '0; bcond = 1'b0; mem_ready = 1'b1; ecall_halt = 1'b0;
        @(posedge clk);
        #1;

        // Directed per-cycle table
        tbl.push_back(mk(0, ARITHMETIC, 1, 1, 0, NONE, "reset_outputs"));
        tbl.push_back(mk(0, LOAD, 0, 1, 1, NONE, "reset_outputs2"));
        tbl.push_back(mk(1, ARITHMETIC, 0, 1, 0, MR | IRW, "add_if"));
        tbl.push_back(mk(1, ARITHMETIC, 0, 1, 0, ASB2, "add_id"));
        tbl.push_back(mk(1, ARITHMETIC, 0, 1, 0, ASA | AOP2, "add_ex"));
        tbl.push_back(mk(1, ARITHMETIC, 0, 1, 0, RW | PCW, "add_wb"));
        tbl.push_back(mk(1, LOAD, 0, 1, 0, MR | IRW, "ld_if"));
        tbl.push_back(mk(1, LOAD, 0, 1, 0, ASB2, "ld_id"));
        tbl.push_back(mk(1, LOAD, 0, 1, 0, ASA | ASB1, "ld_ex"));
        tbl.push_back(mk(1, LOAD, 0, 0, 0, MR | IOD, "ld_mem_w1"));
        tbl.push_back(mk(1, LOAD, 0, 0, 0, MR | IOD, "ld_mem_w2"));
        tbl.push_back(mk(1, LOAD, 0, 1, 0, MR | IOD, "ld_mem_done"));
        tbl.push_back(mk(1, LOAD, 0, 1, 0, RW | PCW | M2R1, "ld_wb"));
        tbl.push_back(mk(1, BRANCH, 0, 1, 0, MR | IRW, "beq1_if"));
        tbl.push_back(mk(1, BRANCH, 0, 1, 0, ASB2, "beq1_id"));
        tbl.push_back(mk(1, BRANCH, 1, 1, 0, ASA | AOP1 | PCW | PCS1, "beq_taken_ex"));
        tbl.push_back(mk(1, BRANCH, 1, 1, 0, MR | IRW, "beq0_if"));
        tbl.push_back(mk(1, BRANCH, 1, 1, 0, ASB2, "beq0_id"));
        tbl.push_back(mk(1, BRANCH, 0, 1, 0, ASA | AOP1 | PCW, "beq_not_taken_ex"));
        tbl.push_back(mk(1, JALR, 0, 0, 0, MR, "jalr_if_wait"));
        tbl.push_back(mk(1, JALR, 0, 1, 0, MR | IRW, "jalr_if"));
        tbl.push_back(mk(1, JALR, 0, 1, 0, ASB2, "jalr_id"));
        tbl.push_back(mk(1, JALR, 0, 1, 0, NONE, "jalr_ex"));
        tbl.push_back(mk(1, JALR, 0, 1, 0, RW | PCW | M2R2 | PCS2, "jalr_wb"));
        tbl.push_back(mk(1, STORE, 0, 1, 0, MR | IRW, "st_if"));
        tbl.push_back(mk(1, STORE, 0, 1, 0, ASB2, "st_id"));
        tbl.push_back(mk(1, STORE, 0, 1, 0, ASA | ASB1, "st_ex"));
        tbl.push_back(mk(1, STORE, 0, 1, 0, MW | IOD | PCW, "st_mem"));
        tbl.push_back(mk(1, BAD_OP, 0, 1, 0, MR | IRW, "bad_if"));
        tbl.push_back(mk(1, BAD_OP, 0, 1, 0, ASB2 | PCW, "bad_id"));
        tbl.push_back(mk(1, ECALL, 0, 1, 0, MR | IRW, "ecall_nh_if"));
        tbl.push_back(mk(1, ECALL, 0, 1, 0, ASB2 | PCW, "ecall_nh_id"));
        foreach (tbl[i]) step(tbl[i]);

        // Reset during the MEM phase of a stalled store
        step(mk(1, STORE, 0, 1, 0, MR | IRW, "rst_st_if"));
        step(mk(1, STORE, 0, 1, 0, ASB2, "rst_st_id"));
        step(mk(1, STORE, 0, 1, 0, ASA | ASB1, "rst_st_ex"));
        mem_ready = 1'b0;
        @(negedge clk);
        check("rst_st_mem", outs(), MW | IOD);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_mem_drop", outs(), NONE);
        @(posedge clk);
        #1 check("rst_mid_mem_hold", outs(), NONE);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_release_fetch", outs(), MR);
        @(posedge clk);
        #1;

        // Random instruction streams against the trace model
        for (int n = 0; n < 200; n++) begin
            logic eh;
`ifdef ECALL_HALT_EN
            eh = 1'b0;
`else
            eh = rb();
`endif
            gen_instr(ops[$urandom_range(0, 8)], rb(), $urandom_range(0, 2), $urandom_range(0, 2), eh);
            while (rq.size() > 0) begin
                v = rq.pop_front();
                step(v);
            end
        end

        // Terminating ECALL
`ifdef ECALL_HALT_EN
        step(mk(1, ECALL, 0, 1, 1, MR | IRW, "halt_if"));
        step(mk(1, ECALL, 0, 0, 1, ASB2, "halt_id"));
        for (int c = 0; c < 20; c++) begin
            step(mk(1, 7'($urandom_range(0, 127)), rb(), rb(), rb(), HLT, "halt_sticky"));
        end
`else
        step(mk(1, ECALL, 0, 1, 1, MR | IRW, "ecall_if"));
        step(mk(1, ECALL, 0, 1, 1, ASB2 | PCW, "ecall_nop_id"));
        step(mk(1, ARITHMETIC, 0, 0, 1, MR, "ecall_next_fetch"));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
